// File: rtl/twiddle_fetch_seq.sv
// Read-side sequencer for a twiddle ROM: walks an address window, absorbs the
// registered ROM latency and streams coefficients over valid/ready with last/done.
module twiddle_fetch_seq #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              tw_valid,
  input  logic              tw_ready,
  output logic [DATA_W-1:0] tw_data,
  output logic              tw_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr_ptr;
  logic [ADDR_W:0]   remaining;
  // s1: address sits on rom_addr; s2: its data sits on rom_data.
  logic              s1, s1_last, s2, s2_last;

  logic [DATA_W-1:0] fifo_data [2];
  logic              fifo_last [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        occ;

  logic              pop, push, issue, last_issue, credit, head_last;
  logic              cmd_bad, accept;
  logic [2:0]        outstanding;
  logic [ADDR_W+1:0] win_end;

  assign tw_valid  = (occ != 2'd0);
  assign tw_data   = fifo_data[rd_ptr];
  assign head_last = fifo_last[rd_ptr];
  assign tw_last   = tw_valid & head_last;
  assign busy      = (state != IDLE);

  assign pop  = tw_valid & tw_ready;
  // With the FIFO full and no pop, the s2 word waits on the ROM output: rom_addr
  // is held (no credit), so the ROM keeps re-reading the same entry.
  assign push = s2 & ((occ != 2'd2) | pop);

  assign win_end = {2'b00, base} + {1'b0, count};
  assign cmd_bad = (count == '0) || (win_end > (ADDR_W+2)'(DEPTH));
  assign accept  = (state == IDLE) && start && !cmd_bad;

  // Words in the system after this edge (before any new issue) must leave room for one more.
  assign outstanding = {1'b0, occ} + {2'b00, s1} + {2'b00, s2};
  assign credit      = (outstanding <= (3'd2 + {2'b00, pop}));
  assign issue       = (state == FETCH) && (remaining != '0) && credit;
  assign last_issue  = issue && (remaining == (ADDR_W+1)'(1));

  // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = FETCH;
      FETCH:   if (last_issue) state_nx = DRAIN;
      DRAIN:   if (pop && head_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rom_addr  <= '0;
      addr_ptr  <= '0;
      remaining <= '0;
      s1        <= 1'b0;
      s1_last   <= 1'b0;
      s2        <= 1'b0;
      s2_last   <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ       <= 2'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      // NOTE: the two FIFO slots are reset too, so tw_data/tw_last read zero out of reset.
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      state <= state_nx;
      err   <= (state == IDLE) && start && cmd_bad;
      done  <= (state == DRAIN) && pop && head_last;

      if (accept) begin
        addr_ptr  <= base;
        remaining <= count;
      end else if (issue) begin
        rom_addr  <= addr_ptr;
        addr_ptr  <= addr_ptr + ADDR_W'(1);
        remaining <= remaining - (ADDR_W+1)'(1);
      end

      s1      <= issue;
      s1_last <= last_issue;
      s2      <= s1 | (s2 & !push);
      s2_last <= s1 ? s1_last : s2_last;

      if (push) begin
        fifo_data[wr_ptr] <= rom_data;
        fifo_last[wr_ptr] <= s2_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_twiddle_fetch_seq.sv
// Self-checking bench for twiddle_fetch_seq: table-driven windows, random windows
// and backpressure against a list-based model, plus mid-window start and reset cases.
module tb_twiddle_fetch_seq;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 28;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base = '0;
  logic [ADDR_W:0]   count = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data = '0;
  logic              tw_valid, tw_ready = 1'b0;
  logic [DATA_W-1:0] tw_data;
  logic              tw_last, busy, done, err;

  twiddle_fetch_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .count(count),
    .rom_addr(rom_addr), .rom_data(rom_data), .tw_valid(tw_valid), .tw_ready(tw_ready),
    .tw_data(tw_data), .tw_last(tw_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // ROM with one-cycle registered read; entries 28..31 are unpopulated markers.
  logic [DATA_W-1:0] rom [32];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Address monitor: every new rom_addr must fall inside the current accepted window.
  bit                mon_en = 1'b0;
  int                addr_lo = 0, addr_hi = 0;
  logic [ADDR_W-1:0] prev_addr = '0;
  always @(negedge clk) begin
    if (mon_en && rom_addr != prev_addr)
      check("addr_in_window", 32'(int'(rom_addr) >= addr_lo && int'(rom_addr) <= addr_hi), 32'd1);
    prev_addr <= rom_addr;
  end

  typedef struct {
    logic [ADDR_W-1:0] b;
    logic [ADDR_W:0]   n;
    bit                rnd;       // random tw_ready instead of held high
    int                poke;      // cycle to inject a stray start, -1 for none
    int                rst_after; // reset after this many handshakes, -1 for none
    bit                exp_err;
  } vec_t;

  vec_t tbl [12];

  task automatic check_reset_values(input string tag);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_tw_valid"}, 32'(tw_valid), 32'd0);
    check({tag, "_tw_data"},  32'(tw_data),  32'd0);
    check({tag, "_tw_last"},  32'(tw_last),  32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_err"},      32'(err),      32'd0);
  endtask

  // Drives one start command and follows the window until done (or a bound expires).
  // Cycle k below is the negedge after start-sampling edge k.
  task automatic run_window(input vec_t v, input string tag);
    logic [DATA_W-1:0] expq [$];
    logic [ADDR_W-1:0] pre_addr;
    logic [DATA_W-1:0] hold_d;
    bit                hold_v, done_seen;
    int                got, cyc, n, vcount;

    n = int'(v.n);
    @(negedge clk);
    pre_addr = rom_addr;
    start = 1'b1; base = v.b; count = v.n; tw_ready = 1'b1;
    if (!v.exp_err) begin
      addr_lo = int'(v.b); addr_hi = int'(v.b) + n - 1; mon_en = 1'b1;
      for (int i = 0; i < n; i++) expq.push_back(rom[int'(v.b) + i]);
    end
    @(negedge clk);
    start = 1'b0;

    if (v.exp_err) begin
      check({tag, "_err_pulse"}, 32'(err), 32'd1);
      check({tag, "_err_busy"},  32'(busy), 32'd0);
      vcount = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        vcount += int'(tw_valid) + int'(busy) + int'(err);
      end
      check({tag, "_err_quiet"}, 32'(vcount), 32'd0);
      check({tag, "_err_addr"},  32'(rom_addr), 32'(pre_addr));
      return;
    end

    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    got = 0; cyc = 0; hold_v = 1'b0; done_seen = 1'b0;
    while (!done_seen && cyc < 40 + 20 * n) begin
      if (hold_v) begin
        check({tag, "_hold_valid"}, 32'(tw_valid), 32'd1);
        check({tag, "_hold_data"},  32'(tw_data),  32'(hold_d));
      end
      if (!v.rnd && cyc == 2) check({tag, "_lat_not_yet"}, 32'(tw_valid), 32'd0);
      if (!v.rnd && cyc == 3) check({tag, "_lat_first"},   32'(tw_valid), 32'd1);
      if (v.poke >= 0 && cyc == v.poke) begin
        start = 1'b1; base = 5'd3; count = 6'd2;
      end
      if (v.poke >= 0 && cyc == v.poke + 1) begin
        start = 1'b0;
        check({tag, "_poke_no_err"}, 32'(err), 32'd0);
      end
      if (done) begin
        done_seen = 1'b1;
        check({tag, "_done_count"}, 32'(got), 32'(n));
        check({tag, "_done_busy"},  32'(busy), 32'd0);
        if (!v.rnd) check({tag, "_done_cycle"}, 32'(cyc), 32'(n + 3));
      end
      tw_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tw_valid && tw_ready) begin
        if (got < n) begin
          check({tag, "_data"}, 32'(tw_data), 32'(expq[got]));
          check({tag, "_last"}, 32'(tw_last), 32'(got == n - 1));
          if (!v.rnd) check({tag, "_beat_cycle"}, 32'(cyc), 32'(3 + got));
        end else begin
          check({tag, "_extra_beat"}, 32'(tw_valid), 32'd0);
        end
        got++;
      end else if (!v.rnd && !done_seen && busy) begin
        check({tag, "_busy_hold"}, 32'(busy), 32'd1);
      end
      hold_v = tw_valid && !tw_ready;
      hold_d = tw_data;

      if (v.rst_after >= 0 && got == v.rst_after) begin
        mon_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values({tag, "_rst"});
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          vcount += int'(tw_valid);
        end
        check({tag, "_rst_no_valid"}, 32'(vcount), 32'd0);
        return;
      end
      @(negedge clk);
      cyc++;
    end
    if (!done_seen) check({tag, "_done_timeout"}, 32'(done_seen), 32'd1);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_valid"}, 32'(tw_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'h1000 + 16'(i);
    for (int i = 0; i < 8; i++)  rom[i] = 16'h0100;
    rom[8]  = 16'h0100; rom[9]  = 16'h00B5; rom[10] = 16'h0000; rom[11] = 16'hFF4A;
    rom[12] = 16'h0000; rom[13] = 16'hFF9E; rom[14] = 16'hFF4A; rom[15] = 16'hFF13;
    rom[24] = 16'h0031; rom[25] = 16'h0025; rom[26] = 16'h0019; rom[27] = 16'h000C;
    for (int i = 28; i < 32; i++) rom[i] = 16'hDEAD;

    //           b      n      rnd poke rst exp_err
    tbl[0]  = '{5'd0,  6'd4,  0, -1, -1, 0};
    tbl[1]  = '{5'd24, 6'd4,  0, -1, -1, 0};
    tbl[2]  = '{5'd8,  6'd8,  1, -1, -1, 0};
    tbl[3]  = '{5'd0,  6'd0,  0, -1, -1, 1};
    tbl[4]  = '{5'd26, 6'd4,  0, -1, -1, 1};
    tbl[5]  = '{5'd0,  6'd10, 0,  4, -1, 0};
    tbl[6]  = '{5'd8,  6'd6,  0, -1,  3, 0};
    tbl[7]  = '{5'd0,  6'd4,  0, -1, -1, 0};
    tbl[8]  = '{5'd27, 6'd1,  0, -1, -1, 0};
    tbl[9]  = '{5'd0,  6'd28, 1, -1, -1, 0};
    tbl[10] = '{5'd1,  6'd28, 0, -1, -1, 1};
    tbl[11] = '{5'd31, 6'd1,  0, -1, -1, 1};

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_window(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 25; i++) begin
      vec_t r;
      int   b, n;
      b = $urandom_range(0, 31);
      n = $urandom_range(0, 12);
      if ($urandom_range(0, 3) == 0) n = $urandom_range(0, 40);
      r.b = 5'(b); r.n = 6'(n); r.rnd = 1'($urandom_range(0, 1));
      r.poke = -1; r.rst_after = -1;
      r.exp_err = (n == 0) || (b + n > DEPTH);
      run_window(r, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
